// File: rtl/sram_controller.sv
// Block-read / word-write bridge between the cache controller and a 256K x 16
// asynchronous SRAM. Reads fetch four halfwords (64 bits); writes store two halfwords.
module sram_controller #(
    parameter int SRAM_AW = 18,
    parameter int SRAM_DW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [63:0]        readData,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    typedef enum logic [3:0] {
        IDLE, RD0, RD1, RD2, RD3, WA0, WB0, WA1, WB1, DONE
    } state_t;

    state_t             state;
    logic [16:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               dq_oe;
    logic [SRAM_DW-1:0] dq_out;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^address[31:17];

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // NOTE: the bus is released whenever we are not writing, so the SRAM can drive it during reads.
    assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DW{1'bz}};

    always_comb begin
        case (state)
            IDLE:    ready = ~(rd_en | wr_en);
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // NOTE: all state and strobes update with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            readData  <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        addr_q    <= address[16:0];
                        wdata_q   <= writeData;
                        SRAM_ADDR <= SRAM_AW'({address[16:0], 1'b0});
                        dq_out    <= SRAM_DW'(writeData[15:0]);
                        dq_oe     <= 1'b1;
                        state     <= WA0;
                    end else if (rd_en) begin
                        addr_q[16:1] <= address[16:1];
                        SRAM_ADDR    <= SRAM_AW'({address[16:1], 2'd0});
                        SRAM_OE_N    <= 1'b0;
                        state        <= RD0;
                    end
                end
                RD0: begin
                    readData[15:0] <= SRAM_DQ[15:0];
                    SRAM_ADDR      <= SRAM_AW'({addr_q[16:1], 2'd1});
                    state          <= RD1;
                end
                RD1: begin
                    readData[31:16] <= SRAM_DQ[15:0];
                    SRAM_ADDR       <= SRAM_AW'({addr_q[16:1], 2'd2});
                    state           <= RD2;
                end
                RD2: begin
                    readData[47:32] <= SRAM_DQ[15:0];
                    SRAM_ADDR       <= SRAM_AW'({addr_q[16:1], 2'd3});
                    state           <= RD3;
                end
                RD3: begin
                    readData[63:48] <= SRAM_DQ[15:0];
                    SRAM_OE_N       <= 1'b1;
                    state           <= DONE;
                end
                WA0: begin
                    SRAM_WE_N <= 1'b0;
                    state     <= WB0;
                end
                WB0: begin
                    // Upper halfword gets its own setup cycle before the second strobe.
                    SRAM_WE_N <= 1'b1;
                    SRAM_ADDR <= SRAM_AW'({addr_q, 1'b1});
                    dq_out    <= SRAM_DW'(wdata_q[31:16]);
                    state     <= WA1;
                end
                WA1: begin
                    SRAM_WE_N <= 1'b0;
                    state     <= WB1;
                end
                WB1: begin
                    SRAM_WE_N <= 1'b1;
                    dq_oe     <= 1'b0;
                    state     <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: SRAM device model plus a halfword-level
// reference memory, directed corner cases and randomized traffic.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] writeData;
    wire  [63:0] readData;
    wire         ready;
    wire  [15:0] SRAM_DQ;
    wire  [17:0] SRAM_ADDR;
    wire         SRAM_WE_N;
    wire         SRAM_OE_N;
    wire         SRAM_CE_N;
    wire         SRAM_UB_N;
    wire         SRAM_LB_N;

    sram_controller #(.SRAM_AW(18), .SRAM_DW(16)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .writeData(writeData),
        .readData(readData), .ready(ready),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    always #5 clk = ~clk;

    // SRAM device: drives the bus on reads; a bench probe drives zero to prove the DUT released it.
    logic [15:0] sram [0:262143];
    logic        probe_en = 1'b0;
    int          we_cycles = 0;

    assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? sram[SRAM_ADDR] :
                     (probe_en ? 16'h0000 : 16'hzzzz);

    always @(negedge clk) begin
        if (!SRAM_WE_N) begin
            sram[SRAM_ADDR] = SRAM_DQ;
            we_cycles++;
        end
    end

    // Reference: halfword-addressed memory and the last completed block.
    logic [15:0] ref_mem [int];
    logic [63:0] last_rd = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [15:0] ref_hw(input logic [17:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_released(input string tag);
        probe_en = 1'b1;
        #1;
        check(tag, {48'd0, SRAM_DQ}, 64'd0);
        probe_en = 1'b0;
        #1;
    endtask

    // Called at a negedge while the DUT is IDLE; returns at the negedge of the following IDLE cycle.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        int          we0;
        logic [63:0] exp_rd;
        logic [17:0] exp_addr;
        logic [15:0] exp_dq;
        logic [1:0]  idx;
        rd_en = rd; wr_en = wr; address = a; writeData = d;
        #1;
        check("req_ready", {63'd0, ready}, {63'd0, ~(rd | wr)});
        we0 = we_cycles;
        exp_rd = last_rd;
        if (!wr)
            exp_rd = {ref_hw({a[16:1], 2'd3}), ref_hw({a[16:1], 2'd2}),
                      ref_hw({a[16:1], 2'd1}), ref_hw({a[16:1], 2'd0})};
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            if (k == 1 && !hold) begin
                #1; rd_en = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
            #1;
            if (k < 5) begin
                check("busy_ready", {63'd0, ready}, 64'd0);
                if (wr) begin
                    exp_addr = {a[16:0], (k > 2)};
                    exp_dq   = (k > 2) ? d[31:16] : d[15:0];
                    check("wr_addr", {46'd0, SRAM_ADDR}, {46'd0, exp_addr});
                    check("wr_dq", {48'd0, SRAM_DQ}, {48'd0, exp_dq});
                    check("wr_we_n", {63'd0, SRAM_WE_N}, {63'd0, !(k == 2 || k == 4)});
                    check("wr_oe_n", {63'd0, SRAM_OE_N}, 64'd1);
                end else begin
                    idx = 2'(k - 1);
                    exp_addr = {a[16:1], idx};
                    check("rd_addr", {46'd0, SRAM_ADDR}, {46'd0, exp_addr});
                    check("rd_oe_n", {63'd0, SRAM_OE_N}, 64'd0);
                    check("rd_we_n", {63'd0, SRAM_WE_N}, 64'd1);
                    check("rd_dq", {48'd0, SRAM_DQ}, {48'd0, ref_hw(exp_addr)});
                end
            end else begin
                check("done_ready", {63'd0, ready}, 64'd1);
                check("done_we_n", {63'd0, SRAM_WE_N}, 64'd1);
                check("done_oe_n", {63'd0, SRAM_OE_N}, 64'd1);
                check("done_data", readData, exp_rd);
                check_released("done_dq_z");
            end
        end
        check("we_pulses", 64'(we_cycles - we0), wr ? 64'd2 : 64'd0);
        if (wr) begin
            ref_mem[int'({a[16:0], 1'b0})] = d[15:0];
            ref_mem[int'({a[16:0], 1'b1})] = d[31:16];
        end else begin
            last_rd = exp_rd;
        end
        @(negedge clk);
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] v);
        sram[a] = v;
        ref_mem[int'(a)] = v;
    endtask

    task automatic idle_checks(input int cycles);
        rd_en = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            check("idle_ready", {63'd0, ready}, 64'd1);
            check("idle_we_n", {63'd0, SRAM_WE_N}, 64'd1);
            check("idle_oe_n", {63'd0, SRAM_OE_N}, 64'd1);
            check("idle_data", readData, last_rd);
            check_released("idle_dq_z");
        end
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        bit          hold;
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; writeData = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", {63'd0, ready}, 64'd1);
        check("rst_we_n", {63'd0, SRAM_WE_N}, 64'd1);
        check("rst_oe_n", {63'd0, SRAM_OE_N}, 64'd1);
        check("rst_addr", {46'd0, SRAM_ADDR}, 64'd0);
        check("rst_data", readData, 64'd0);
        check("rst_tied", {61'd0, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 64'd0);
        check_released("rst_dq_z");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed block read of preloaded halfwords, then a word write.
        preload(18'h00008, 16'h1111);
        preload(18'h00009, 16'h2222);
        preload(18'h0000A, 16'h3333);
        preload(18'h0000B, 16'h4444);
        do_req(1'b1, 1'b0, 32'h0000_0005, 32'h0, 1'b0);
        check("block_read", readData, 64'h4444_3333_2222_1111);
        do_req(1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0);
        check("sram_lo", {48'd0, sram[18'h0000A]}, 64'h0000_0000_0000_BEEF);
        check("sram_hi", {48'd0, sram[18'h0000B]}, 64'h0000_0000_0000_DEAD);
        do_req(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);

        // Both requests held: only writes, back to back every six cycles.
        do_req(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_0001, 1'b1);
        do_req(1'b1, 1'b1, 32'h0000_0011, 32'hCAFE_0002, 1'b1);
        do_req(1'b1, 1'b1, 32'h0000_0012, 32'hCAFE_0003, 1'b0);

        // Address wrap at the top of the SRAM, upper address bits ignored.
        do_req(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0);
        do_req(1'b0, 1'b1, 32'h0001_FFFF, 32'h5A5A_A5A5, 1'b0);
        do_req(1'b1, 1'b0, 32'h0001_FFFE, 32'h0, 1'b0);
        check("wrap_read", readData[63:32], 64'h0000_0000_5A5A_A5A5);

        idle_checks(8);

        // Reset while in RD2: strobes drop at once and readData clears.
        rd_en = 1'b1; address = 32'h0000_0004;
        repeat (3) @(posedge clk);
        rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("abort_oe_n", {63'd0, SRAM_OE_N}, 64'd1);
        @(negedge clk);
        #1;
        check("abort_ready", {63'd0, ready}, 64'd1);
        check("abort_oe_n2", {63'd0, SRAM_OE_N}, 64'd1);
        check("abort_we_n", {63'd0, SRAM_WE_N}, 64'd1);
        check("abort_data", readData, 64'd0);
        check_released("abort_dq_z");
        last_rd = '0;
        @(negedge clk);
        rst = 1'b0;
        idle_checks(3);

        // Random traffic confined to a small window so reads hit earlier writes.
        for (int t = 0; t < 60; t++) begin
            a = $urandom();
            a[16:6] = '0;
            op = $urandom_range(0, 2);
            hold = ($urandom_range(0, 3) == 0);
            do_req(op != 1, op != 0, a, $urandom(), hold);
        end
        idle_checks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
